// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: hazard/branch/memory status in, freeze/flush controls
// and statistics out. The controller uses the slave modport, the datapath
// (or a bench) uses the master modport.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             branch_taken;
  logic             forward_en;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_use_src1;
  logic             id_two_src;
  logic [3:0]       exe_dest;
  logic [3:0]       mem_dest;
  logic             exe_wb_en;
  logic             mem_wb_en;
  logic             exe_mem_read;
  logic             mem_req;
  logic             mem_ready;
  logic             err_clr;
  logic             pc_freeze;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_exe_flush;
  logic             freeze_all;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output branch_taken, forward_en, id_src1, id_src2, id_use_src1, id_two_src,
           exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_read,
           mem_req, mem_ready, err_clr,
    input  pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
           freeze_all, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  branch_taken, forward_en, id_src1, id_src2, id_use_src1, id_two_src,
           exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_read,
           mem_req, mem_ready, err_clr,
    output pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
           freeze_all, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / branch / memory-wait controller with a timeout error
// state and saturating stall and flush statistics counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hz;
  logic mstall;
  logic freeze;
  logic do_flush;
  logic do_stall;

  // Data hazard between ID sources and EXE/MEM destinations
  always_comb begin
    logic ex_m1, ex_m2, mm_m1, mm_m2;
    ex_m1 = bus.id_use_src1 & (bus.id_src1 == bus.exe_dest);
    ex_m2 = bus.id_two_src  & (bus.id_src2 == bus.exe_dest);
    mm_m1 = bus.id_use_src1 & (bus.id_src1 == bus.mem_dest);
    mm_m2 = bus.id_two_src  & (bus.id_src2 == bus.mem_dest);
    if (bus.forward_en)
      hz = bus.exe_mem_read & (ex_m1 | ex_m2);
    else
      hz = (bus.exe_wb_en & (ex_m1 | ex_m2)) | (bus.mem_wb_en & (mm_m1 | mm_m2));
  end

  // Freeze and flush/stall priority: freeze > branch > hazard
  always_comb begin
    mstall   = bus.mem_req & ~bus.mem_ready;
    freeze   = (state_q == ERR) | mstall;
    do_flush = ~freeze & bus.branch_taken;
    do_stall = ~freeze & ~bus.branch_taken & hz;
  end

  // Next-state: memory-wait FSM and saturating statistics counters
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (mstall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mstall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d    = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERR: begin
        if (bus.err_clr) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    // mem_err is registered off the next state so it tracks ERR exactly
    mem_err_d = (state_d == ERR);
    if (do_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (do_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Output drive
  always_comb begin
    bus.freeze_all   = freeze;
    bus.pc_freeze    = do_stall;
    bus.if_id_freeze = do_stall;
    bus.if_id_flush  = do_flush;
    bus.id_exe_flush = do_flush | do_stall;
    bus.mem_err      = mem_err_q;
    bus.stall_cnt    = stall_cnt_q;
    bus.flush_cnt    = flush_cnt_q;
  end

endmodule
